// File: rtl/fighter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fighter_pkg
// Purpose  : Shared fighter-state encoding, keycode constants and small
//            helpers used by the animation FSM and its position register.
// Revision : 1.0 - initial release
// ============================================================================
package fighter_pkg;

  // Fixed ordering: hit detection, sprite ROM select and the enemy AI all
  // decode these numeric values directly, so never reorder.
  typedef enum logic [6:0] {
    STAND = 7'd0, FIGHT, WALK, RUN, PUNCH, KICK, VICTORY, DEATH, REVERENCE,
    SWITCH0_0, SWITCH0_1, SWITCH0_2, SWITCH0_3, SWITCH0_4,
    SWITCH1_0, SWITCH1_1, SWITCH1_2, SWITCH1_3, SWITCH1_4,
    WALK1, WALK2, WALK3, WALK4, WALK5, WALK6, WALK7, WALK8, WALK9,
    RUN1, RUN2, RUN3, RUN4, RUN5, RUN6, RUN7, RUN8, RUN9,
    REVERENCE1, REVERENCE2, REVERENCE3, REVERENCE4, REVERENCE5,
    PUNCH1, PUNCH2, PUNCH3, PUNCH4, PUNCH5,
    PUNCH6, PUNCH7, PUNCH8, PUNCH9, PUNCH10,
    KICK1, KICK2, KICK3, KICK4,
    VICTORY1,
    DEATH1, DEATH2, DEATH3, DEATH4
  } fighter_state_t;

  localparam logic [7:0] KEY_FWD   = 8'h04;
  localparam logic [7:0] KEY_BACK  = 8'h07;
  localparam logic [7:0] KEY_STAND = 8'h54;
  localparam logic [7:0] KEY_FIGHT = 8'h55;
  localparam logic [7:0] KEY_PUNCH = 8'h56;
  localparam logic [7:0] KEY_KICK  = 8'h57;
  localparam logic [7:0] KEY_BOW   = 8'h58;

  // States belonging to a sequence that must run to completion.
  function automatic logic is_busy(input fighter_state_t s);
    return s inside {[SWITCH0_0:SWITCH1_4], [PUNCH1:PUNCH5], PUNCH,
                     [KICK1:KICK4], KICK, [REVERENCE1:REVERENCE5],
                     [DEATH1:DEATH3]};
  endfunction

  // Successor of a busy state. The attack chains splice the shared
  // PUNCH/KICK impact frame into the middle of their numbered frames.
  function automatic fighter_state_t chain_next(input fighter_state_t s);
    case (s)
      SWITCH0_4:  return FIGHT;
      SWITCH1_4:  return STAND;
      PUNCH2:     return PUNCH;
      PUNCH:      return PUNCH3;
      PUNCH5:     return FIGHT;
      KICK2:      return KICK;
      KICK:       return KICK3;
      KICK4:      return FIGHT;
      REVERENCE5: return REVERENCE;
      default:    return fighter_state_t'(s + 7'd1);
    endcase
  endfunction

  // Signed displacement: +mag when moving toward larger X, else -mag.
  function automatic logic signed [10:0] signed_step(input logic pos,
                                                     input logic signed [10:0] mag);
    return pos ? mag : -mag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fighter_anim_fsm_xpos.sv
`default_nettype none
// ============================================================================
// Module   : fighter_xpos
// Purpose  : Horizontal position register. When loaded it adds a signed step
//            and clamps the result to [X_MIN, X_MAX].
// Revision : 1.0 - initial release
// ============================================================================
module fighter_xpos #(
  parameter int X_INIT = 100,
  parameter int X_MIN  = 16,
  parameter int X_MAX  = 600
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               ld_i,
  input  logic signed [10:0] step_i,
  output logic [9:0]         x_o
);

  localparam logic signed [10:0] C_MIN = 11'(X_MIN);
  localparam logic signed [10:0] C_MAX = 11'(X_MAX);

  logic [9:0]         x_q;
  logic [9:0]         x_d;
  logic signed [10:0] w_sum;
  logic signed [10:0] w_clamp;

  // Signed sum and clamp; at a limit the position simply holds.
  always_comb begin
    w_sum   = $signed({1'b0, x_q}) + step_i;
    w_clamp = (w_sum < C_MIN) ? C_MIN : ((w_sum > C_MAX) ? C_MAX : w_sum);
    x_d     = ld_i ? 10'(w_clamp) : x_q;
  end

  // Position register with synchronous reset to the spawn point.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q <= 10'(X_INIT);
    end else begin
      x_q <= x_d;
    end
  end

  assign x_o = x_q;

endmodule
`default_nettype wire

// File: rtl/fighter_anim_fsm.sv
`default_nettype none
// ============================================================================
// Module   : fighter_anim_fsm
// Purpose  : Converts a fighter's keycode stream into its animation state
//            code and X position, advancing one frame per frame_tick.
// Revision : 1.0 - initial release
// ============================================================================
module fighter_anim_fsm
  import fighter_pkg::*;
#(
  parameter int X_INIT    = 100,
  parameter int X_MIN     = 16,
  parameter int X_MAX     = 600,
  parameter bit FACE_LEFT = 1'b0,
  parameter int WALK_STEP = 4,
  parameter int RUN_STEP  = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       death_in,
  input  logic       victory_in,
  output logic [6:0] state,
  output logic [9:0] x_pos,
  output logic       busy,
  output logic       impact
);

  localparam logic signed [10:0] C_WALK = 11'(WALK_STEP);
  localparam logic signed [10:0] C_RUN  = 11'(RUN_STEP);

  fighter_state_t     state_q, state_d;
  logic               dir_q, dir_d;          // 1: latched walk moves toward +X
  logic               death_pend_q, death_pend_d;
  logic               vic_pend_q, vic_pend_d;
  logic               w_death_eff, w_vic_eff;
  logic               w_busy;
  logic               w_key_dir, w_key_pos;
  logic               w_x_ld;
  logic signed [10:0] w_x_step;

  assign w_busy      = is_busy(state_q);
  // A request arriving on the tick cycle itself is acted on at that tick.
  assign w_death_eff = death_pend_q | death_in;
  assign w_vic_eff   = vic_pend_q | victory_in;
  assign w_key_dir   = (keycode == KEY_FWD) || (keycode == KEY_BACK);
  // Forward means -X for a left-facing fighter.
  assign w_key_pos   = (keycode == KEY_FWD) ^ FACE_LEFT;

  // Request latches: every tick consumes death; victory is consumed on any
  // tick where no sequence is running, and a death request discards it.
  assign death_pend_d = frame_tick ? 1'b0 : w_death_eff;
  assign vic_pend_d   = (w_death_eff || (frame_tick && !w_busy)) ? 1'b0 : w_vic_eff;

  // Next-state and position-step decode, evaluated only on a frame tick.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    w_x_ld   = 1'b0;
    w_x_step = '0;
    if (frame_tick) begin
      if (state_q inside {DEATH1, DEATH2, DEATH3}) begin
        state_d = fighter_state_t'(state_q + 7'd1);
      end else if (state_q == DEATH4) begin
        state_d = DEATH4;
      end else if (w_death_eff) begin
        state_d = DEATH1;
      end else if (w_busy) begin
        state_d = chain_next(state_q);
      end else if (state_q inside {VICTORY1, VICTORY}) begin
        state_d = VICTORY;
      end else if (w_vic_eff) begin
        state_d = VICTORY1;
      end else if (state_q == STAND) begin
        if (keycode == KEY_FIGHT) begin
          state_d = SWITCH0_0;
        end else if (keycode == KEY_BOW) begin
          state_d = REVERENCE1;
        end else if (keycode == KEY_FWD) begin
          state_d  = RUN1;
          w_x_ld   = 1'b1;
          w_x_step = signed_step(!FACE_LEFT, C_RUN);
        end
      end else if (state_q == FIGHT) begin
        if (keycode == KEY_STAND) begin
          state_d = SWITCH1_0;
        end else if (keycode == KEY_PUNCH) begin
          state_d = PUNCH1;
        end else if (keycode == KEY_KICK) begin
          state_d = KICK1;
        end else if (w_key_dir) begin
          state_d  = WALK1;
          dir_d    = w_key_pos;
          w_x_ld   = 1'b1;
          w_x_step = signed_step(w_key_pos, C_WALK);
        end
      end else if (state_q inside {[WALK1:WALK9]}) begin
        if (w_key_dir) begin
          w_x_ld = 1'b1;
          if (state_q == WALK9) begin
            state_d  = WALK1;
            dir_d    = w_key_pos;
            w_x_step = signed_step(w_key_pos, C_WALK);
          end else begin
            state_d  = fighter_state_t'(state_q + 7'd1);
            w_x_step = signed_step(dir_q, C_WALK);
          end
        end else begin
          state_d = FIGHT;
        end
      end else if (state_q inside {[RUN1:RUN9]}) begin
        if (keycode == KEY_FWD) begin
          state_d  = (state_q == RUN9) ? RUN1 : fighter_state_t'(state_q + 7'd1);
          w_x_ld   = 1'b1;
          w_x_step = signed_step(!FACE_LEFT, C_RUN);
        end else begin
          state_d = STAND;
        end
      end else if (state_q == REVERENCE) begin
        state_d = (keycode == KEY_BOW) ? REVERENCE : STAND;
      end else begin
        // Reserved codes recover to the guard pose.
        state_d = FIGHT;
      end
    end
  end

  // State, walk direction and request latches.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= STAND;
      dir_q        <= 1'b0;
      death_pend_q <= 1'b0;
      vic_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      death_pend_q <= death_pend_d;
      vic_pend_q   <= vic_pend_d;
    end
  end

  fighter_xpos #(
    .X_INIT (X_INIT),
    .X_MIN  (X_MIN),
    .X_MAX  (X_MAX)
  ) u_xpos (
    .Clk    (Clk),
    .Reset  (Reset),
    .ld_i   (w_x_ld),
    .step_i (w_x_step),
    .x_o    (x_pos)
  );

  assign state  = state_q;
  assign busy   = w_busy;
  assign impact = (state_q == PUNCH) || (state_q == KICK);

endmodule
`default_nettype wire

// File: doc/fighter_anim_fsm.md
Name: fighter_anim_fsm

Overview:
- Consumes the 8-bit keycode stream produced by the keyboard path (hero) or the enemy AI (enemy).
- Turns that stream into the fighter's animation state code and horizontal position.
- The state code uses the shared fighter-state encoding, so hit detection, sprite ROM selection and the enemy AI read it directly.
- One instance per fighter. Frame advance is gated by a one-cycle enable; there are no derived clocks.

Parameters:
- X_INIT, 100, x_pos value at reset.
- X_MIN, 16, lowest legal x_pos.
- X_MAX, 600, highest legal x_pos.
- FACE_LEFT, 0, when 1 "forward" decreases X (enemy instance); when 0 forward increases X.
- WALK_STEP, 4, pixels moved per WALKn frame.
- RUN_STEP, 8, pixels moved per RUNn frame.

Ports:
- Clk  in  1  system clock; sole clock.
- Reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle animation-advance enable.
- keycode  in  8  command byte: 0x04 forward, 0x07 backward, 0x54 stand, 0x55 fight, 0x56 punch, 0x57 kick, 0x58 bow; any other value = idle.
- death_in  in  1  death request (level or pulse).
- victory_in  in  1  victory request (level or pulse).
- state  out  7  current fighter_state_t code.
- x_pos  out  10  fighter X position.
- busy  out  1  1 while in a non-interruptible sequence.
- impact  out  1  1 while state is PUNCH or KICK.

Behaviour:
- Reset: state=STAND, x_pos=X_INIT, busy=0, impact=0, death and victory latches cleared. Reset in mid-sequence aborts the sequence.
- Timing: state and x_pos change only on a Clk edge with frame_tick=1. keycode is sampled on that same edge. There is no other latency.
- Latches: death_in=1 on any cycle sets death_pend; victory_in=1 on any cycle sets vic_pend. Both hold until acted on or Reset.
- Priority at each tick, highest first:
  1. death_pend
  2. busy chain continues
  3. vic_pend
  4. keycode decode
- Death: from any state except the DEATH chain, go DEATH1→DEATH2→DEATH3→DEATH4. DEATH4 holds until Reset; keycode and victory are ignored.
- Victory: acted on only when not busy. Go VICTORY1→VICTORY, and VICTORY holds until Reset.
- STAND decode:
  - 0x55 → SWITCH0_0..SWITCH0_4 → FIGHT (busy).
  - 0x58 → REVERENCE1..REVERENCE5 (busy) → REVERENCE. REVERENCE holds while 0x58 is present, otherwise → STAND.
  - 0x04 → RUN1.
  - Any other code → stay in STAND.
- FIGHT decode:
  - 0x54 → SWITCH1_0..SWITCH1_4 → STAND (busy).
  - 0x56 → PUNCH1→PUNCH2→PUNCH→PUNCH3→PUNCH4→PUNCH5→FIGHT (busy).
  - 0x57 → KICK1→KICK2→KICK→KICK3→KICK4→FIGHT (busy).
  - 0x04 or 0x07 → WALK1, with the walk direction latched at entry.
  - Any other code → stay in FIGHT.
- Walk:
  - WALK1..WALK9 advance one per tick; every WALKn frame moves x_pos by WALK_STEP in the latched direction.
  - At WALK9: a directional code → WALK1 with direction re-latched; otherwise → FIGHT.
  - A non-directional code on WALK1..WALK8 → FIGHT immediately.
- Run:
  - RUN1..RUN9 loop while keycode=0x04; otherwise → STAND. Each RUNn frame moves forward by RUN_STEP.
  - There is no backward run; 0x07 in STAND is ignored.
- Direction mapping: forward = −X if FACE_LEFT=1, else +X. Backward is the opposite.
- Position arithmetic:
  - Compute in 11-bit signed, then clamp to [X_MIN, X_MAX].
  - At a limit the animation continues and x_pos holds.
  - x_pos is never written outside walk or run frames.
- Unreachable codes: WALK, RUN and PUNCH6..PUNCH10 are reserved. If entered, the next tick goes to FIGHT.
- Combinational outputs:
  - busy=1 in SWITCH0_*, SWITCH1_*, PUNCH1..PUNCH5, PUNCH, KICK1..KICK4, KICK, REVERENCE1..REVERENCE5, DEATH1..DEATH3.
  - impact=1 exactly in PUNCH and KICK, one frame each per attack.
- Simultaneous events:
  - death_in and victory_in in the same cycle → death wins and vic_pend is cleared.
  - death_in during an attack → the next tick enters DEATH1; the attack is abandoned.

Decomposition:
- Package fighter_pkg holds:
  - fighter_state_t: 7-bit enum in fixed order STAND=0, FIGHT, WALK, RUN, PUNCH, KICK, VICTORY, DEATH, REVERENCE, SWITCH0_0..SWITCH0_4, SWITCH1_0..SWITCH1_4, WALK1..WALK9, RUN1..RUN9, REVERENCE1..REVERENCE5, PUNCH1..PUNCH10, KICK1..KICK4, VICTORY1, DEATH1..DEATH4 (=60).
  - Keycode constants KEY_FWD, KEY_BACK, KEY_STAND, KEY_FIGHT, KEY_PUNCH, KEY_KICK, KEY_BOW.
- One sub-module, fighter_xpos: signed step plus clamp, written as a register with load enable.

Test Plan:
- Reset, then keycode=0x55 for 6 ticks → SWITCH0_0..SWITCH0_4 with busy=1, then FIGHT with busy=0; x_pos=100 throughout.
- In FIGHT, keycode=0x56 for 1 tick then 0x00 → full punch chain completes; impact=1 only on the 3rd tick (state=PUNCH=4); FIGHT after 7 ticks.
- FACE_LEFT=1, X_INIT=500, in FIGHT, keycode=0x04 held for 9 ticks → WALK1..WALK9 and x_pos=464; the 10th tick gives WALK1 and x_pos=460.
- X_INIT=596, STAND, keycode=0x04 held → RUN1 gives x_pos=600, RUN2 holds 600 (clamped at X_MAX) while state keeps advancing.
- Mid-kick (KICK1), pulse death_in for one non-tick cycle → next tick DEATH1, then DEATH4 after 4 ticks; DEATH4 holds for 20 ticks with keycode=0x56 applied.
- death_in and victory_in asserted in the same cycle while in FIGHT → DEATH1 on the next tick and VICTORY never reached. Reset asserted mid-walk → STAND and x_pos=X_INIT on the next edge, independent of frame_tick.
